parallel_to_serial: RTL and testbench

Transmit-side counterpart of serial_to_parallel. Accepts width-bit words over a valid/ready handshake and emits them one bit per cycle on a serial valid/ready interface, LSB first by default. A one-word holding register lets the next word be accepted while the current one shifts out, so a continuously fed stream leaves no idle cycles between words. serial_valid/serial_data connect directly to a serial_to_parallel instance for loopback.

---
 rtl/parallel_to_serial.sv | 87 ++++++++
 tb/tb_parallel_to_serial.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/parallel_to_serial.sv
// parallel_to_serial: serializes width-bit words onto a bit-wide valid/ready stream through a one-word holding register.
module parallel_to_serial #(
  parameter int width = 8,
  parameter bit msb_first = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             parallel_valid,
  output logic             parallel_ready,
  input  logic [width-1:0] parallel_data,
  output logic             serial_valid,
  input  logic             serial_ready,
  output logic             serial_data,
  output logic             serial_last,
  output logic             busy
);
  localparam int cw = $clog2(width);
  localparam logic [cw-1:0] last_idx = cw'(width - 1);
  logic [width-1:0] shift_q, shift_d, hold_q, hold_d, load_word;
  logic [cw-1:0] cnt_q, cnt_d;
  logic hold_full_q, hold_full_d, valid_q, valid_d, data_q, data_d, last_q, last_d, ready_q;
  logic accept, xfer, frees, load;
  always_comb begin
    accept = parallel_valid & ready_q;
    xfer = valid_q & serial_ready;
    frees = ~valid_q | (xfer & last_q);
    load = frees & (hold_full_q | accept);
    load_word = hold_full_q ? hold_q : parallel_data;
    shift_d = shift_q;
    hold_d = hold_q;
    hold_full_d = hold_full_q;
    cnt_d = cnt_q;
    valid_d = valid_q;
    data_d = data_q;
    last_d = last_q;
    if (load) begin
      // a word arriving while the held word moves to the shifter takes its slot
      valid_d = 1'b1;
      cnt_d = '0;
      last_d = 1'b0;
      data_d = msb_first ? load_word[width-1] : load_word[0];
      shift_d = msb_first ? load_word << 1 : load_word >> 1;
      hold_full_d = hold_full_q & accept;
      hold_d = (hold_full_q & accept) ? parallel_data : hold_q;
    end else if (frees) begin
      valid_d = 1'b0;
      last_d = 1'b0;
    end else begin
      if (xfer) begin
        cnt_d = cnt_q + 1'b1;
        last_d = (cnt_q + 1'b1) == last_idx;
        data_d = msb_first ? shift_q[width-1] : shift_q[0];
        shift_d = msb_first ? shift_q << 1 : shift_q >> 1;
      end
      if (accept) begin
        hold_d = parallel_data;
        hold_full_d = 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shift_q <= '0;
      hold_q <= '0;
      hold_full_q <= 1'b0;
      cnt_q <= '0;
      valid_q <= 1'b0;
      data_q <= 1'b0;
      last_q <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      shift_q <= shift_d;
      hold_q <= hold_d;
      hold_full_q <= hold_full_d;
      cnt_q <= cnt_d;
      valid_q <= valid_d;
      data_q <= data_d;
      last_q <= last_d;
      ready_q <= ~hold_full_d;
    end
  end
  assign parallel_ready = ready_q;
  assign serial_valid = valid_q;
  assign serial_data = data_q;
  assign serial_last = last_q;
  assign busy = valid_q | hold_full_q;
endmodule

// File: tb/tb_parallel_to_serial.sv
// tb_parallel_to_serial: random and directed stimulus checked every cycle against a word/bit-queue model.
module tb_parallel_to_serial;
  localparam int W = 8;
  logic clk, rst_n, parallel_valid, serial_ready;
  logic [W-1:0] parallel_data;
  logic ready0, ready1, sv0, sv1, sd0, sd1, last0, last1, busy0, busy1;
  parallel_to_serial #(.width(W), .msb_first(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .parallel_valid(parallel_valid), .parallel_ready(ready0),
    .parallel_data(parallel_data), .serial_valid(sv0), .serial_ready(serial_ready),
    .serial_data(sd0), .serial_last(last0), .busy(busy0));
  parallel_to_serial #(.width(W), .msb_first(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .parallel_valid(parallel_valid), .parallel_ready(ready1),
    .parallel_data(parallel_data), .serial_valid(sv1), .serial_ready(serial_ready),
    .serial_data(sd1), .serial_last(last1), .busy(busy1));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  int n_chk = 0, n_fail = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  // model: accepted words become bit queues; outstanding words decide ready/valid/busy
  bit q0[$], q1[$];
  logic [W-1:0] rx0[$], rx1[$];
  int out = 0, n_acc = 0, nbits = 0, nlast = 0;
  bit up = 0, started = 0, xfer, fin, acc;
  logic [W-1:0] log0, log1, a0, a1;
  always @(posedge clk) begin
    started = 1;
    if (!rst_n) begin
      out = 0;
      q0.delete();
      q1.delete();
      up = 0;
    end else begin
      xfer = out > 0 && serial_ready;
      fin = xfer && (q0.size() % W == 1);
      acc = parallel_valid && up && out < 2;
      if (xfer) begin
        log0 = {log0[W-2:0], sd0};
        log1 = {log1[W-2:0], sd1};
        nbits++;
        if (last0) nlast++;
        a0 = {sd0, a0[W-1:1]};
        a1 = {a1[W-2:0], sd1};
        void'(q0.pop_front());
        void'(q1.pop_front());
        if (fin) begin
          rx0.push_back(a0);
          rx1.push_back(a1);
        end
      end
      if (acc) begin
        for (int i = 0; i < W; i++) q0.push_back(parallel_data[i]);
        for (int i = 0; i < W; i++) q1.push_back(parallel_data[W-1-i]);
        n_acc++;
      end
      out = out + int'(acc) - int'(fin);
      up = 1;
    end
  end
  bit count_sv = 0, prev_sv = 0;
  int svc = 0, falls = 0;
  always @(negedge clk) begin
    if (started) begin
      chk("ready0", ready0, up && out < 2);
      chk("ready1", ready1, up && out < 2);
      chk("valid0", sv0, out > 0);
      chk("valid1", sv1, out > 0);
      chk("busy0", busy0, out > 0);
      chk("busy1", busy1, out > 0);
      if (out > 0) begin
        chk("data0", sd0, q0[0]);
        chk("data1", sd1, q1[0]);
        chk("last0", last0, q0.size() % W == 1);
        chk("last1", last1, q1.size() % W == 1);
      end
      if (count_sv) begin
        if (sv0) svc++;
        if (prev_sv && !sv0) falls++;
        prev_sv = sv0;
      end
    end
  end
  bit rand_sr = 0;
  always @(negedge clk) if (rand_sr) serial_ready = 1'($urandom_range(0, 1));
  task automatic send(input logic [W-1:0] w);
    int n0 = n_acc;
    parallel_valid = 1'b1;
    parallel_data = w;
    for (int k = 0; k < 200 && n_acc == n0; k++) @(negedge clk);
    if (n_acc == n0) begin
      n_chk++;
      n_fail++;
      $display("FAIL send_timeout: word %0h not accepted", w);
    end
    parallel_valid = 1'b0;
  endtask
  task automatic wait_idle(input int n);
    for (int k = 0; k < n && out != 0; k++) @(negedge clk);
    @(negedge clk);
    chk("idle_busy", busy0, 0);
  endtask
  task automatic wait_bits(input int n);
    for (int k = 0; k < 50 && nbits < n; k++) @(negedge clk);
    chk("bit_count", nbits, n);
  endtask
  task automatic clr();
    log0 = '0;
    log1 = '0;
    nbits = 0;
    nlast = 0;
    rx0.delete();
    rx1.delete();
  endtask
  logic f_d, f_v, f_l;
  logic [W-1:0] sent[$];
  logic [W-1:0] w;
  initial begin
    rst_n = 1'b0;
    parallel_valid = 1'b1;
    parallel_data = 8'hAA;
    serial_ready = 1'b1;
    clr();
    repeat (2) @(negedge clk);
    chk("rst_ready", ready0, 0);
    chk("rst_valid", sv0, 0);
    chk("rst_busy", busy0, 0);
    rst_n = 1'b1;
    parallel_valid = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", ready0, 1);
    chk("no_accept_in_rst", busy0, 0);
    clr();
    send(8'hC1);
    wait_idle(20);
    chk("single_lsb", log0, 8'b10000011);
    chk("single_msb", log1, 8'b11000001);
    chk("single_nbits", nbits, 8);
    chk("single_nlast", nlast, 1);
    chk("single_valid_off", sv0, 0);
    clr();
    count_sv = 1;
    send(8'h01);
    send(8'h80);
    chk("b2b_ready_low", ready0, 0);
    wait_idle(40);
    count_sv = 0;
    chk("b2b_valid_cycles", svc, 16);
    chk("b2b_gaps", falls, 1);
    chk("b2b_words", rx0.size(), 2);
    if (rx0.size() == 2) begin
      chk("b2b_word0", rx0[0], 8'h01);
      chk("b2b_word1", rx0[1], 8'h80);
    end
    clr();
    send(8'hC1);
    wait_bits(2);
    serial_ready = 1'b0;
    f_d = sd0;
    f_v = sv0;
    f_l = last0;
    chk("bp_frozen_bit", f_d, 0);
    repeat (3) begin
      @(negedge clk);
      chk("bp_hold_data", sd0, f_d);
      chk("bp_hold_valid", sv0, f_v);
      chk("bp_hold_last", last0, f_l);
    end
    chk("bp_no_xfer", nbits, 2);
    serial_ready = 1'b1;
    wait_idle(20);
    chk("bp_word", log0, 8'b10000011);
    clr();
    send(8'hFF);
    wait_bits(4);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_valid", sv0, 0);
    chk("midrst_busy", busy0, 0);
    rst_n = 1'b1;
    @(negedge clk);
    clr();
    send(8'h00);
    wait_idle(20);
    chk("midrst_zero_word", log0, 8'h00);
    chk("midrst_nbits", nbits, 8);
    clr();
    rand_sr = 1;
    for (int i = 0; i < 100; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      w = W'($urandom);
      sent.push_back(w);
      send(w);
    end
    rand_sr = 0;
    serial_ready = 1'b1;
    wait_idle(400);
    chk("loop_count0", rx0.size(), 100);
    chk("loop_count1", rx1.size(), 100);
    if (rx0.size() == 100 && rx1.size() == 100)
      for (int i = 0; i < 100; i++) begin
        chk("loop_word_lsb", rx0[i], sent[i]);
        chk("loop_word_msb", rx1[i], sent[i]);
      end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
